// File: rtl/set_cfg_bank_if.sv
// +----------------------------------------------------------------------------+
// | set_cfg_bank_if: settings-bus bundle between bus controller and cfg bank.  |
// | SET_READBACK_EN adds the rd_data readback image.     Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface set_cfg_bank_if #(
    parameter int NFLAG = 7,
    parameter int TW    = 4
);
    localparam int AW = NFLAG + TW;

    logic             bact;
    logic             set_cswr;
    logic [AW-1:0]    a;
    logic [NFLAG-1:0] slow;
    logic [TW-1:0]    slow_timeout;
    logic             armed;
    logic             bad_wr;
`ifdef SET_READBACK_EN
    logic [NFLAG+TW:0] rd_data;

    modport master (output bact, set_cswr, a,
                    input  slow, slow_timeout, armed, bad_wr, rd_data);
    modport slave  (input  bact, set_cswr, a,
                    output slow, slow_timeout, armed, bad_wr, rd_data);
`else
    modport master (output bact, set_cswr, a,
                    input  slow, slow_timeout, armed, bad_wr);
    modport slave  (input  bact, set_cswr, a,
                    output slow, slow_timeout, armed, bad_wr);
`endif
endinterface

`default_nettype wire

// File: rtl/set_cfg_bank.sv
// +----------------------------------------------------------------------------+
// | set_cfg_bank: slow-path flags + timeout, written by address-encoded bus    |
// | writes behind a key/payload unlock. Option macro: SET_READBACK_EN.  Rev 1.0|
// +----------------------------------------------------------------------------+
`default_nettype none

module set_cfg_bank #(
    parameter int                 NFLAG     = 7,
    parameter int                 TW        = 4,
    parameter int                 KW        = 8,
    parameter logic [KW-1:0]      KEY       = 8'hA5,
    parameter int                 ARM_TO    = 15,
    parameter logic [NFLAG-1:0]   RST_FLAGS = 7'b0110011,
    parameter logic [TW-1:0]      RST_TO    = 4'hF
) (
    input  logic           clk,
    input  logic           rst_n,
    set_cfg_bank_if.slave  bus
);
    localparam int AW = NFLAG + TW;
    localparam int CW = (ARM_TO < 1) ? 1 : $clog2(ARM_TO + 1);
    localparam logic [CW-1:0] c_arm_load = CW'(ARM_TO);

    localparam logic [0:0] S_LOCKED = 1'b0;
    localparam logic [0:0] S_ARMED  = 1'b1;

    logic             r_s1;
    logic             r_s2;
    logic [AW-1:0]    r_ar;
    logic             w_req;
    logic             w_stb;
    logic             w_key_hit;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_commit;
    logic             w_bad;

    logic [NFLAG-1:0] r_slow;
    logic [NFLAG-1:0] w_slow_nxt;
    logic [TW-1:0]    r_to;
    logic [TW-1:0]    w_to_nxt;
    logic             r_bad;

    assign w_req     = bus.bact && bus.set_cswr;
    assign w_stb     = r_s1 && !r_s2;
    assign w_key_hit = (r_ar[KW-1:0] == KEY);

    // Request edge detect; the address is only captured while a request is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_ar <= '0;
        end else begin
            r_s1 <= w_req;
            r_s2 <= r_s1;
            if (w_req) begin
                r_ar <= bus.a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOCKED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A strobe while armed beats the timeout, so a payload on the last cycle commits.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOCKED: if (w_stb && w_key_hit) w_state_nxt = S_ARMED;
            S_ARMED:  if (w_stb || (r_cnt == '0)) w_state_nxt = S_LOCKED;
            default:  w_state_nxt = S_LOCKED;
        endcase
    end

    always_comb begin
        w_commit  = 1'b0;
        w_bad     = 1'b0;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_LOCKED: begin
                if (w_stb && w_key_hit) begin
                    w_cnt_nxt = c_arm_load;
                end else if (w_stb) begin
                    w_bad = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_stb) begin
                    w_commit = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign w_slow_nxt = w_commit ? r_ar[NFLAG-1:0]  : r_slow;
    assign w_to_nxt   = w_commit ? r_ar[AW-1:NFLAG] : r_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slow <= RST_FLAGS;
            r_to   <= RST_TO;
            r_bad  <= 1'b0;
        end else begin
            r_slow <= w_slow_nxt;
            r_to   <= w_to_nxt;
            r_bad  <= w_bad;
        end
    end

    assign bus.slow         = r_slow;
    assign bus.slow_timeout = r_to;
    assign bus.armed        = (r_state == S_ARMED);
    assign bus.bad_wr       = r_bad;

`ifdef SET_READBACK_EN
    // Built from next-state values so the image tracks the live outputs in the same cycle.
    logic [NFLAG+TW:0] r_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= {1'b0, RST_TO, RST_FLAGS};
        end else begin
            r_rd <= {(w_state_nxt == S_ARMED), w_to_nxt, w_slow_nxt};
        end
    end

    assign bus.rd_data = r_rd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_set_cfg_bank.sv
// +----------------------------------------------------------------------------+
// | tb_set_cfg_bank: directed + randomized bench with a behavioural model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

module tb_set_cfg_bank;
    localparam int          NFLAG  = 7;
    localparam int          TW     = 4;
    localparam int          AW     = NFLAG + TW;
    localparam logic [7:0]  KEY    = 8'hA5;
    localparam int          ARM_TO = 15;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    set_cfg_bank_if #(.NFLAG(NFLAG), .TW(TW)) bus ();

    set_cfg_bank #(
        .NFLAG(NFLAG), .TW(TW), .KW(8), .KEY(KEY), .ARM_TO(ARM_TO),
        .RST_FLAGS(7'b0110011), .RST_TO(4'hF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a write is an event on the edge after its first sampled cycle;
    // the arm window is an absolute edge deadline rather than a down-counter.
    logic [NFLAG-1:0] m_slow;
    logic [TW-1:0]    m_to;
    logic             m_armed;
    logic             m_bad;
    int               m_deadline;
    int               cyc;
    logic             req_prev;
    logic             pend;
    int               pend_edge;
    logic [AW-1:0]    pend_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slow   = 7'b0110011;
            m_to     = 4'hF;
            m_armed  = 1'b0;
            m_bad    = 1'b0;
            cyc      = 0;
            req_prev = 1'b0;
            pend     = 1'b0;
        end else begin
            cyc++;
            m_bad = 1'b0;
            if (pend && pend_edge == cyc) begin
                pend = 1'b0;
                if (!m_armed) begin
                    if (pend_a[7:0] == KEY) begin
                        m_armed    = 1'b1;
                        m_deadline = cyc + ARM_TO + 1;
                    end else begin
                        m_bad = 1'b1;
                    end
                end else begin
                    m_slow  = pend_a[NFLAG-1:0];
                    m_to    = pend_a[AW-1:NFLAG];
                    m_armed = 1'b0;
                end
            end else if (m_armed && cyc >= m_deadline) begin
                m_armed = 1'b0;
            end
            if (bus.bact && bus.set_cswr && !req_prev) begin
                pend      = 1'b1;
                pend_edge = cyc + 1;
                pend_a    = bus.a;
            end
            req_prev = bus.bact && bus.set_cswr;
        end
    end

    always @(negedge clk) begin
        chk("slow",         32'(bus.slow),         32'(m_slow));
        chk("slow_timeout", 32'(bus.slow_timeout), 32'(m_to));
        chk("armed",        32'(bus.armed),        32'(m_armed));
        chk("bad_wr",       32'(bus.bad_wr),       32'(m_bad));
`ifdef SET_READBACK_EN
        chk("rd_data", 32'(bus.rd_data), 32'({m_armed, m_to, m_slow}));
`endif
    end

    task automatic wr(input logic [AW-1:0] addr, input int hold);
        bus.bact     = 1'b1;
        bus.set_cswr = 1'b1;
        bus.a        = addr;
        repeat (hold) @(posedge clk);
        #1;
        bus.bact     = 1'b0;
        bus.set_cswr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_bad(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.bad_wr) cnt++;
        end
    endtask

    int nb;
    int hi;
    int guard;

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.bact     = 1'b0;
        bus.set_cswr = 1'b0;
        bus.a        = '0;
        #12 rst_n = 1'b1;
        idle(2);
        chk("reset_slow", 32'(bus.slow), 32'h33);
        chk("reset_to",   32'(bus.slow_timeout), 32'hF);

        // Key held three cycles arms once, then payload commits.
        wr(11'h0A5, 3);
        idle(1);
        chk("armed_after_key", 32'(bus.armed), 32'h1);
        wr(11'h1C1, 1);
        idle(3);
        chk("commit_slow",  32'(bus.slow), 32'h41);
        chk("commit_to",    32'(bus.slow_timeout), 32'h3);
        chk("commit_armed", 32'(bus.armed), 32'h0);

        // Async reset pulse in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("por_slow",  32'(bus.slow), 32'h33);
        chk("por_to",    32'(bus.slow_timeout), 32'hF);
        chk("por_armed", 32'(bus.armed), 32'h0);
        #1 rst_n = 1'b1;
        idle(2);

        // Wrong key while locked.
        wr(11'h05A, 1);
        count_bad(5, nb);
        chk("badwr_pulses", 32'(nb), 32'h1);
        chk("badwr_slow",   32'(bus.slow), 32'h33);

        // Arm window expiry.
        wr(11'h0A5, 1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.armed && guard < 10);
        chk("arm_seen", 32'(bus.armed), 32'h1);
        hi = 1;
        guard = 0;
        while (guard < 40) begin
            @(negedge clk);
            guard++;
            if (!bus.armed) break;
            hi++;
        end
        chk("arm_window_len", 32'(hi), 32'd16);
        wr(11'h1C1, 1);
        count_bad(5, nb);
        chk("late_payload_bad", 32'(nb), 32'h1);
        chk("late_payload_slow", 32'(bus.slow), 32'h33);

        // Payload strobe lands on the last armed cycle.
        @(posedge clk);
        #1;
        wr(11'h0A5, 1);
        idle(15);
        wr(11'h2AA, 1);
        idle(2);
        chk("last_cycle_slow",  32'(bus.slow), 32'h2A);
        chk("last_cycle_to",    32'(bus.slow_timeout), 32'h5);
        chk("last_cycle_armed", 32'(bus.armed), 32'h0);

        // Reset on the commit edge wins.
        wr(11'h0A5, 1);
        idle(2);
        wr(11'h7FF, 1);
        @(posedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst_commit_slow", 32'(bus.slow), 32'h33);
        chk("rst_commit_to",   32'(bus.slow_timeout), 32'hF);
        #2 rst_n = 1'b1;
        idle(2);

        // Randomized traffic with varying density and key bias.
        for (int blk = 0; blk < 40; blk++) begin
            int dens;
            dens = $urandom_range(0, 3);
            for (int c = 0; c < 50; c++) begin
                logic [AW-1:0] ra;
                @(posedge clk);
                #1;
                ra = AW'($urandom);
                if ($urandom_range(0, 9) < 4) ra[7:0] = KEY;
                bus.a        = ra;
                bus.bact     = (dens == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
                bus.set_cswr = (dens == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, dens) != 0);
                if ($urandom_range(0, 499) == 0) begin
                    rst_n = 1'b0;
                    #2 rst_n = 1'b1;
                end
            end
        end
        bus.bact     = 1'b0;
        bus.set_cswr = 1'b0;
        idle(4);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
